// File: rtl/iomem_ctrl_pkg.sv
// Shared types and defaults for the iomem sequencer/decoder.
// State encoding, default map, error word, counter width helper.
package iomem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0]  BASE_PAGE_DEF = 8'h03;
  localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_DEF   = 16;
  localparam int          CNT_W_DEF     = $clog2(TIMEOUT_DEF);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iomem_req_t;

  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/iomem_ctrl_if.sv
// iomem bus bundle: SoC master side (m_*) and peripheral slot side (s_*).
// slave = controller view, master = SoC + peripherals view.
interface iomem_ctrl_if #(
  parameter int NUM_SLAVES = 4
);

  logic                    m_valid;
  logic                    m_ready;
  logic [3:0]              m_wstrb;
  logic [31:0]             m_addr;
  logic [31:0]             m_wdata;
  logic [31:0]             m_rdata;

  logic [NUM_SLAVES-1:0]   s_valid;
  logic [NUM_SLAVES-1:0]   s_ready;
  logic [3:0]              s_wstrb;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [32*NUM_SLAVES-1:0] s_rdata;

  modport slave (
    input  m_valid, m_wstrb, m_addr, m_wdata,
    input  s_ready, s_rdata,
    output m_ready, m_rdata,
    output s_valid, s_wstrb, s_addr, s_wdata
  );

  modport master (
    output m_valid, m_wstrb, m_addr, m_wdata,
    output s_ready, s_rdata,
    input  m_ready, m_rdata,
    input  s_valid, s_wstrb, s_addr, s_wdata
  );

endinterface

// File: rtl/iomem_ctrl_decode.sv
// Combinational page decoder: page in, hit + slot index out.
// Ports: page[7:0] in; hit, idx[2:0] out.
module iomem_decode
  import iomem_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_PAGE  = BASE_PAGE_DEF,
  parameter int         NUM_SLAVES = 4
) (
  input  logic [7:0] page,
  output logic       hit,
  output logic [2:0] idx
);

  logic [7:0] off;

  assign off = page - BASE_PAGE;
  // page >= BASE guards against 8-bit wrap of off
  assign hit = (page >= BASE_PAGE) && (off < 8'(NUM_SLAVES));
  assign idx = off[2:0];

endmodule

// File: rtl/iomem_ctrl.sv
// iomem sequencer: registers a request, routes it to one slot, bounds wait.
// Ports: clk, reset, bus (slave modport), err_count[7:0], err_addr[31:0].
module iomem_ctrl
  import iomem_ctrl_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [7:0]  BASE_PAGE  = BASE_PAGE_DEF,
  parameter int          TIMEOUT    = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic         clk,
  input  logic         reset,
  iomem_ctrl_if.slave  bus,
  output logic [7:0]   err_count,
  output logic [31:0]  err_addr
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  iomem_req_t            req;
  logic                  hit;
  logic [2:0]            idx;
  logic [NUM_SLAVES-1:0] oh;
  logic                  sel_rdy;
  logic [31:0]           sel_rdata;
  logic [7:0]            err_inc;

  iomem_decode #(
    .BASE_PAGE  (BASE_PAGE),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_dec (
    .page (bus.m_addr[31:24]),
    .hit  (hit),
    .idx  (idx)
  );

  always_comb begin
    oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      oh[i] = (idx == 3'(i));
  end

  // s_valid is one-hot, so it doubles as the slot select;
  // other slots' ready/rdata are masked out here.
  assign sel_rdy = |(bus.s_ready & bus.s_valid);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (bus.s_valid[i])
        sel_rdata = bus.s_rdata[32*i +: 32];
  end

  assign err_inc = (err_count == 8'hFF) ? err_count
                                        : err_count + 8'd1;

  assign bus.s_addr  = req.addr;
  assign bus.s_wdata = req.wdata;
  assign bus.s_wstrb = req.wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req         <= '0;
      err_count   <= '0;
      err_addr    <= '0;
      bus.m_ready <= 1'b0;
      bus.m_rdata <= '0;
      bus.s_valid <= '0;
    end else begin
      bus.m_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          // m_ready high means the SoC still holds the
          // finished request's m_valid this cycle
          if (bus.m_valid && !bus.m_ready) begin
            req.addr  <= bus.m_addr;
            req.wdata <= bus.m_wdata;
            req.wstrb <= bus.m_wstrb;
            cnt       <= '0;
            if (hit) begin
              bus.s_valid <= oh;
              state       <= ST_BUSY;
            end else begin
              bus.m_rdata <= ERR_DATA;
              err_addr    <= bus.m_addr;
              err_count   <= err_inc;
              state       <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          if (sel_rdy) begin
            bus.m_rdata <= sel_rdata;
            bus.s_valid <= '0;
            state       <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            bus.m_rdata <= ERR_DATA;
            bus.s_valid <= '0;
            err_addr    <= req.addr;
            err_count   <= err_inc;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          bus.m_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_ctrl.sv
// Directed bench for iomem_ctrl: mapped, unmapped, timeout,
// race, noise, reset mid-transaction and error saturation.
module tb_iomem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  err_count;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] D0 = 32'h0BAD_F00D;
  localparam logic [31:0] D1 = 32'hCAFE_0001;
  localparam logic [31:0] D2 = 32'h1234_5678;
  localparam logic [31:0] D3 = 32'h3333_3333;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  iomem_ctrl_if #(.NUM_SLAVES(4)) bus ();

  iomem_ctrl #(
    .NUM_SLAVES (4),
    .BASE_PAGE  (8'h03),
    .TIMEOUT    (16),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  // Drives one request; slot rs raises ready so it is sampled
  // k edges after s_valid rises. ns >= 0 toggles noise ready.
  // lat counts the edge that sampled m_valid as cycle 1.
  task automatic do_txn(
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  int          rs,
    input  int          k,
    input  int          ns,
    output int          lat,
    output logic [31:0] rd,
    output logic [3:0]  sv,
    output int          svc,
    output logic [31:0] sad,
    output logic [31:0] swd
  );
    int n;
    bit done;
    lat = -1; rd = '0; sv = '0; svc = 0;
    sad = '0; swd = '0; n = 0; done = 0;
    @(negedge clk);
    bus.m_valid = 1'b1;
    bus.m_addr  = addr;
    bus.m_wstrb = wstrb;
    bus.m_wdata = wdata;
    @(posedge clk);
    while (!done && n < 64) begin
      @(negedge clk);
      sv = sv | bus.s_valid;
      if (bus.s_valid != '0) begin
        svc++;
        sad = bus.s_addr;
        swd = bus.s_wdata;
      end
      bus.s_ready = '0;
      if (rs >= 0 && n + 1 == k)
        bus.s_ready[rs[1:0]] = 1'b1;
      if (ns >= 0)
        bus.s_ready[ns[1:0]] = n[0];
      if (bus.m_ready) begin
        lat  = n + 1;
        rd   = bus.m_rdata;
        done = 1;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    bus.m_valid = 1'b0;
    bus.s_ready = '0;
  endtask

  int          lat, svc;
  logic [31:0] rd, sad, swd;
  logic [3:0]  sv;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.m_ready !== 1'b0 || bus.s_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_hs m_ready=%b s_valid=%b want 0 0",
               bus.m_ready, bus.s_valid);
    end
    checks++;
    if (bus.m_rdata !== 32'h0 || bus.s_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data m_rdata=%h s_addr=%h want 0 0",
               bus.m_rdata, bus.s_addr);
    end
    checks++;
    if (bus.s_wdata !== 32'h0 || bus.s_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_w s_wdata=%h s_wstrb=%h want 0 0",
               bus.s_wdata, bus.s_wstrb);
    end
    checks++;
    if (err_count !== 8'd0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_err cnt=%0d addr=%h want 0 0",
               err_count, err_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_gpio_write();
    do_txn(32'h0300_0000, 4'hF, 32'h0000_A5A5, 0, 1, -1,
           lat, rd, sv, svc, sad, swd);
    checks++;
    if (sv !== 4'b0001 || swd !== 32'h0000_A5A5) begin
      errors++;
      $display("FAIL gpio_sv s_valid=%b s_wdata=%h want 0001 0000a5a5",
               sv, swd);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL gpio_lat got %0d want 3", lat);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL gpio_err got %0d want 0", err_count);
    end
  endtask

  task automatic test_read_slot2();
    do_txn(32'h0500_0010, 4'h0, 32'h0, 2, 4, -1,
           lat, rd, sv, svc, sad, swd);
    checks++;
    if (rd !== D2 || lat !== 6) begin
      errors++;
      $display("FAIL rd2 rdata=%h lat=%0d want %h 6", rd, lat, D2);
    end
    checks++;
    if (sv !== 4'b0100 || svc !== 4 || sad !== 32'h0500_0010) begin
      errors++;
      $display("FAIL rd2_sv sv=%b cyc=%0d addr=%h want 0100 4 05000010",
               sv, svc, sad);
    end
  endtask

  task automatic test_unmapped();
    do_txn(32'h0800_0000, 4'h0, 32'h0, -1, 0, -1,
           lat, rd, sv, svc, sad, swd);
    checks++;
    if (sv !== 4'b0000 || lat !== 2 || rd !== ERRW) begin
      errors++;
      $display("FAIL unmap sv=%b lat=%0d rd=%h want 0000 2 %h",
               sv, lat, rd, ERRW);
    end
    checks++;
    if (err_count !== 8'd1 || err_addr !== 32'h0800_0000) begin
      errors++;
      $display("FAIL unmap_err cnt=%0d addr=%h want 1 08000000",
               err_count, err_addr);
    end
  endtask

  task automatic test_timeout();
    do_txn(32'h0400_0020, 4'h0, 32'h0, -1, 0, -1,
           lat, rd, sv, svc, sad, swd);
    checks++;
    if (sv !== 4'b0010 || svc !== 16) begin
      errors++;
      $display("FAIL tmo_sv sv=%b cyc=%0d want 0010 16", sv, svc);
    end
    checks++;
    if (lat !== 18 || rd !== ERRW) begin
      errors++;
      $display("FAIL tmo_resp lat=%0d rd=%h want 18 %h", lat, rd, ERRW);
    end
    checks++;
    if (err_count !== 8'd2 || err_addr !== 32'h0400_0020) begin
      errors++;
      $display("FAIL tmo_err cnt=%0d addr=%h want 2 04000020",
               err_count, err_addr);
    end
  endtask

  task automatic test_race();
    do_txn(32'h0400_0004, 4'h0, 32'h0, 1, 16, -1,
           lat, rd, sv, svc, sad, swd);
    checks++;
    if (lat !== 18 || rd !== D1 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL race lat=%0d rd=%h cnt=%0d want 18 %h 2",
               lat, rd, err_count, D1);
    end
  endtask

  task automatic test_noise();
    do_txn(32'h0400_0008, 4'h0, 32'h0, 1, 5, 3,
           lat, rd, sv, svc, sad, swd);
    checks++;
    if (lat !== 7 || rd !== D1 || sv !== 4'b0010) begin
      errors++;
      $display("FAIL noise lat=%0d rd=%h sv=%b want 7 %h 0010",
               lat, rd, sv, D1);
    end
    checks++;
    if (err_count !== 8'd2) begin
      errors++;
      $display("FAIL noise_err got %0d want 2", err_count);
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h0300_0040;
    bus.m_wstrb = 4'h0;
    bus.m_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.s_valid !== 4'b0001) begin
      errors++;
      $display("FAIL rstb_pre s_valid=%b want 0001", bus.s_valid);
    end
    reset = 1'b1;
    bus.m_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_valid !== 4'b0 || bus.m_ready !== 1'b0 ||
        err_count !== 8'd0) begin
      errors++;
      $display("FAIL rstb sv=%b rdy=%b cnt=%0d want 0 0 0",
               bus.s_valid, bus.m_ready, err_count);
    end
    reset = 1'b0;
    do_txn(32'h0300_0000, 4'h0, 32'h0, 0, 2, -1,
           lat, rd, sv, svc, sad, swd);
    checks++;
    if (lat !== 4 || rd !== D0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL rstb_fresh lat=%0d rd=%h cnt=%0d want 4 %h 0",
               lat, rd, err_count, D0);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      do_txn(32'h0400_0100 + 32'(i), 4'h0, 32'h0, -1, 0, -1,
             lat, rd, sv, svc, sad, swd);
      if (i == 253) begin
        checks++;
        if (err_count !== 8'd254) begin
          errors++;
          $display("FAIL sat_254 got %0d want 254", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_255 got %0d want 255", err_count);
    end
    checks++;
    if (err_addr !== 32'h0400_022B || lat !== 18) begin
      errors++;
      $display("FAIL sat_addr addr=%h lat=%0d want 0400022b 18",
               err_addr, lat);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.m_valid = 1'b0;
    bus.m_addr  = '0;
    bus.m_wstrb = '0;
    bus.m_wdata = '0;
    bus.s_ready = '0;
    bus.s_rdata = {D3, D2, D1, D0};
    test_reset();
    test_gpio_write();
    test_read_slot2();
    test_unmapped();
    test_timeout();
    test_race();
    test_noise();
    test_reset_busy();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
